// File: rtl/wb_cpu_arbiter.sv
// wb_cpu_arbiter: round-robin two-master Wishbone arbiter, optional watchdog via WB_ARB_TIMEOUT_EN
module wb_cpu_arbiter #(
  parameter int TIMEOUT_BITS = 8
) (
  input  logic        wbm_clk_i,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:2] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:2] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:2] wbm_addr_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_data_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [1:0]  gnt_o
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_GNT0 = 2'b01, S_GNT1 = 2'b10} state_t;
  state_t state, state_n;
  logic last, timeout, g0, g1, stb_raw;
  assign g0 = state == S_GNT0;
  assign g1 = state == S_GNT1;
  assign gnt_o = state;
  assign stb_raw = g0 ? m0_stb_i : g1 & m1_stb_i;
  always_ff @(posedge wbm_clk_i) begin
    if (rst) begin
      state <= S_IDLE;
      last <= 1'b1;
    end else begin
      state <= state_n;
      if (state_n != S_IDLE) last <= state_n == S_GNT1;
    end
  end
  always_comb begin
    state_n = g0 && m0_cyc_i ? S_GNT0 :
              g1 && m1_cyc_i ? S_GNT1 :
              g0             ? (m1_cyc_i ? S_GNT1 : S_IDLE) :
              g1             ? (m0_cyc_i ? S_GNT0 : S_IDLE) :
              m0_cyc_i && (!m1_cyc_i || last) ? S_GNT0 :
              m1_cyc_i       ? S_GNT1 : S_IDLE;
  end
  always_comb begin
    wbm_cyc_o  = (g0 ? m0_cyc_i : g1 & m1_cyc_i) & ~timeout;
    wbm_stb_o  = stb_raw & ~timeout;
    wbm_we_o   = g0 ? m0_we_i : g1 & m1_we_i;
    wbm_addr_o = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
    wbm_cti_o  = g0 ? m0_cti_i : g1 ? m1_cti_i : '0;
    wbm_bte_o  = g0 ? m0_bte_i : g1 ? m1_bte_i : '0;
    wbm_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    wbm_data_o = g0 ? m0_data_i : g1 ? m1_data_i : '0;
    m0_data_o  = g0 ? wbm_data_i : '0;
    m1_data_o  = g1 ? wbm_data_i : '0;
    m0_ack_o   = wbm_ack_i & m0_cyc_i & g0 & ~rst;
    m1_ack_o   = wbm_ack_i & m1_cyc_i & g1 & ~rst;
    m0_err_o   = (wbm_err_i | timeout) & m0_cyc_i & g0 & ~rst;
    m1_err_o   = (wbm_err_i | timeout) & m1_cyc_i & g1 & ~rst;
  end
`ifdef WB_ARB_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] wd_cnt;
  // fires in the cycle that would carry the count to all-ones; a response that cycle wins
  assign timeout = stb_raw & ~wbm_ack_i & ~wbm_err_i & (wd_cnt == {{(TIMEOUT_BITS-1){1'b1}}, 1'b0});
  always_ff @(posedge wbm_clk_i) begin
    if (rst || state_n != state || wbm_ack_i || wbm_err_i || timeout) wd_cnt <= '0;
    else if (stb_raw) wd_cnt <= wd_cnt + TIMEOUT_BITS'(1);
  end
`else
  assign timeout = TIMEOUT_BITS < 0;
`endif
endmodule

// File: doc/wb_cpu_arbiter.md
# wb_cpu_arbiter

Two-master Wishbone arbiter that shares the single CPU-side Wishbone bus between the instruction-fetch connector (master 0) and the data load/store connector (master 1). Each master sees a private Wishbone slave port. The arbiter grants the shared master port to one requester at a time, holds the grant for the whole `cyc` (burst-safe), and routes `ack`/`err`/read data back only to the owner. An optional watchdog terminates cycles that no slave answers.

## Interface
- `TIMEOUT_BITS`, default 8: watchdog counter width. The timeout fires after 2^TIMEOUT_BITS−1 unanswered strobe cycles (255 by default).
- `wbm_clk_i`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`, in, 1 each: master 0 cycle, strobe and write enable.
- `m0_addr_i`, in, [31:2]: master 0 word address.
- `m0_cti_i`, in, 3: master 0 cycle type identifier.
- `m0_bte_i`, in, 2: master 0 burst type extension.
- `m0_sel_i`, in, 4: master 0 byte selects.
- `m0_data_i`, in, 32: master 0 write data.
- `m0_data_o`, out, 32: read data to master 0. Equals `wbm_data_i` while master 0 holds the grant, otherwise 0.
- `m0_ack_o`, `m0_err_o`, out, 1 each: cycle termination to master 0.
- `m1_*`: same set of ports as `m0_*`, for master 1.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, out, 1 each: shared bus cycle, strobe and write enable.
- `wbm_addr_o`, out, [31:2]: shared bus address.
- `wbm_cti_o`, out, 3; `wbm_bte_o`, out, 2; `wbm_sel_o`, out, 4; `wbm_data_o`, out, 32: shared bus cycle type, burst type, byte selects and write data.
- `wbm_data_i`, `wbm_ack_i`, `wbm_err_i`, in: shared bus read data, acknowledge and error.
- `gnt_o`, out, 2: one-hot current owner. 2'b00 means idle.

## Operation
- **State register:** `state` ∈ {S_IDLE, S_GNT0, S_GNT1}, plus a `last` bit recording the most recently granted master.
- **Leaving S_IDLE:**
  - Only m0_cyc_i high → S_GNT0.
  - Only m1_cyc_i high → S_GNT1.
  - Both high → grant the master ≠ `last` (round-robin). `last` updates on entry to S_GNTx.
- **In S_GNTx while mx_cyc_i is high:** stay. The grant is never pre-empted, so bursts and multi-beat cycles stay atomic.
- **In S_GNTx when mx_cyc_i is low:**
  - Other master's cyc high → go directly to S_GNTy (no idle cycle).
  - Otherwise → S_IDLE.
- **Shared bus outputs:** a combinational mux of the owner's inputs, selected by `state`. In S_IDLE all `wbm_*` outputs are 0.
- **Owner responses:**
  - `mx_ack_o = wbm_ack_i & mx_cyc_i & owner`.
  - `mx_err_o = (wbm_err_i | timeout) & mx_cyc_i & owner`.
  - The non-owner always sees ack=0, err=0, data=0.
- **Simultaneous wbm_ack_i and wbm_err_i:** both are forwarded unchanged. The slave is responsible for avoiding this.
- **Reset values:** state=S_IDLE, last=1 (master 0 wins the first contention), watchdog=0. All outputs are 0.
- **Reset mid-cycle:** the grant is dropped at that edge. The shared `cyc`/`stb` are 0 from the next cycle. No ack is forwarded in the reset cycle.

## Timing
- **Grant latency:** one cycle. With mx_cyc_i sampled high at edge N in S_IDLE, `wbm_cyc_o` is high from cycle N+1.
- **Handover:** zero dead cycles. When master x drops cyc at edge N and y is requesting, y drives the bus in cycle N+1.
- **Response path:** combinational from slave to owner. `ack` reaches the master in the same cycle as `wbm_ack_i`.
- **gnt_o:** registered state decode. It changes only on clock edges.

## Configuration
- **`WB_ARB_TIMEOUT_EN` defined:**
  - A TIMEOUT_BITS counter increments each cycle that `wbm_stb_o` is high and `wbm_ack_i`/`wbm_err_i` are both low.
  - It clears on ack, on err, on a state change, or on the timeout itself.
  - When the counter reaches all-ones, `timeout` is high for one cycle. The owner gets `mx_err_o`=1, and `wbm_cyc_o`/`wbm_stb_o` are forced to 0 in that cycle.
  - If ack and timeout occur in the same cycle, ack wins: no err, counter clears.
- **`WB_ARB_TIMEOUT_EN` undefined:** no counter and `timeout`≡0. Errors come only from `wbm_err_i`, and a silent slave hangs the owner indefinitely.

## Test plan
- **Lone m0 read:** m0 single read of addr 0x100 with the slave acking on its 2nd stb cycle, data 0xDEADBEEF → `wbm_cyc_o` rises 1 cycle after m0_cyc_i. m0_ack_o pulses 1 cycle with m0_data_o=0xDEADBEEF. m1 sees no ack/err/data. gnt_o returns to 00.
- **First contention after reset:** both cyc rise in the same cycle → gnt_o=01 (m0). When m0 drops cyc, gnt_o=10 the next cycle with no 00 gap. A second simultaneous request after both idle → m0 again (last=1 after m1).
- **Burst atomicity:** m1 4-beat incrementing burst (cti=010) with m0 requesting throughout → all four acks go to m1 and `wbm_cti_o`/`wbm_addr_o` track m1. m0 is granted only after m1_cyc_i falls.
- **Slave error:** wbm_err_i on m1 write → m1_err_o=1 for that cycle, m1_ack_o=0, m0_err_o=0.
- **Reset mid-cycle:** rst asserted while S_GNT0 and awaiting ack → next cycle gnt_o=00, all wbm_* outputs 0. An ack arriving in the reset cycle is not forwarded.
- **Watchdog (`WB_ARB_TIMEOUT_EN`, TIMEOUT_BITS=4):** m0 strobes with no slave response → m0_err_o pulses exactly on the 15th stb cycle with wbm_cyc_o=0 in that cycle. Without the macro, no err is produced after 1000 cycles.
